// File: rtl/strobe_capture_bank_if.sv
// Output port of the strobe capture bank: one captured word per valid/ready handshake.
//   out_valid  captured word presented (driven by bank)
//   out_ready  consumer accepts when out_valid & out_ready
//   out_data   captured word of the selected channel
//   out_ch     index of the selected channel
//   out_ovr    selected channel overran since its last read
interface strobe_capture_bank_if #(
  parameter int W  = 8,
  parameter int CW = 2
);
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_ch;
  logic          out_ovr;

  modport master (output out_valid, out_data, out_ch, out_ovr, input out_ready);
  modport slave  (input out_valid, out_data, out_ch, out_ovr, output out_ready);
endinterface

// File: rtl/strobe_capture_bank.sv
// Multi-channel strobe capture bank. Each channel edge-detects its strobe in the clk
// domain, captures its data word into a hold register, and the bank presents held words
// one at a time on a valid/ready port with round-robin arbitration.
//   clk, reset  sole clock; asynchronous active-high reset
//   strb        per-channel strobe (synchronous to clk)
//   mode        per-channel fire mode: 00 level, 01 rise, 10 fall, 11 either edge
//   din         per-channel data, ch k = din[W*k +: W]
//   out_if      captured-word output port (valid/ready)
//   pend        per-channel hold-register-full flags

// One channel: edge detect, hold register, pending and overrun flags.
// hold_d/ovr_d are exported so the output stage can follow a capture into the
// presented channel without an extra cycle of staleness.
module strobe_capture_lane #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         strb,
  input  logic [1:0]   mode,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         pend_q,
  output logic [W-1:0] hold_d,
  output logic         ovr_d
);
  logic         strb_q;
  logic [W-1:0] hold_q;
  logic         ovr_q;
  logic         pend_d;
  logic         fire;

  always_comb begin
    fire = 1'b0;
    case (mode)
      2'b00:   fire = strb;
      2'b01:   fire = strb & ~strb_q;
      2'b10:   fire = ~strb & strb_q;
      default: fire = strb ^ strb_q;
    endcase
    hold_d = fire ? din : hold_q;
    // A fire coinciding with the pop of this channel refills it cleanly.
    pend_d = fire | (pend_q & ~pop);
    ovr_d  = fire ? (pend_q & ~pop) : (ovr_q & ~pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      strb_q <= 1'b0;
      hold_q <= '0;
      pend_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      strb_q <= strb;
      hold_q <= hold_d;
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
    end
  end
endmodule

module strobe_capture_bank #(
  parameter int W   = 8,
  parameter int NCH = 4,
  parameter int CW  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NCH-1:0]        strb,
  input  logic [2*NCH-1:0]      mode,
  input  logic [W*NCH-1:0]      din,
  strobe_capture_bank_if.master out_if,
  output logic [NCH-1:0]        pend
);
  typedef enum logic {IDLE, PRESENT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] sel_q, sel_d;
  logic [CW-1:0] ptr_q, ptr_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_ovr_q, out_ovr_d;

  logic [NCH-1:0] pop_vec;
  logic [W-1:0]   hold_d [NCH];
  logic [NCH-1:0] ovr_d;

  logic [CW-1:0] sel_nxt;
  logic [CW-1:0] idx;
  logic          found;

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    strobe_capture_lane #(.W(W)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .strb   (strb[k]),
      .mode   (mode[2*k +: 2]),
      .din    (din[W*k +: W]),
      .pop    (pop_vec[k]),
      .pend_q (pend[k]),
      .hold_d (hold_d[k]),
      .ovr_d  (ovr_d[k])
    );
  end

  // Handshake pops the presented channel.
  always_comb begin
    pop_vec = '0;
    if (state_q == PRESENT && out_if.out_ready) pop_vec[sel_q] = 1'b1;
  end

  // Round-robin: first pending channel at or after ptr, wrapping.
  always_comb begin
    found   = 1'b0;
    sel_nxt = '0;
    idx     = '0;
    for (int i = 0; i < NCH; i++) begin
      idx = CW'((int'(ptr_q) + i) % NCH);
      if (!found && pend[idx]) begin
        found   = 1'b1;
        sel_nxt = idx;
      end
    end
  end

  // Output data/ovr load next-state lane values so a capture in the select or
  // present cycle shows up one cycle later, matching the hold register.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    out_data_d = out_data_q;
    out_ovr_d  = out_ovr_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = PRESENT;
          sel_d      = sel_nxt;
          out_data_d = hold_d[sel_nxt];
          out_ovr_d  = ovr_d[sel_nxt];
        end
      end
      default: begin
        out_data_d = hold_d[sel_q];
        out_ovr_d  = ovr_d[sel_q];
        if (out_if.out_ready) begin
          state_d = IDLE;
          ptr_d   = (sel_q == CW'(NCH-1)) ? '0 : sel_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      ptr_q      <= '0;
      out_data_q <= '0;
      out_ovr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      out_data_q <= out_data_d;
      out_ovr_q  <= out_ovr_d;
    end
  end

  assign out_if.out_valid = (state_q == PRESENT);
  assign out_if.out_data  = out_data_q;
  assign out_if.out_ch    = sel_q;
  assign out_if.out_ovr   = out_ovr_q;
endmodule

// File: tb/tb_strobe_capture_bank.sv
module tb_strobe_capture_bank;
  localparam int W   = 8;
  localparam int NCH = 4;
  localparam int CW  = 2;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NCH-1:0]       strb = '0;
  logic [2*NCH-1:0]     mode = '0;
  logic [W*NCH-1:0]     din = '0;
  logic [NCH-1:0]       pend;

  strobe_capture_bank_if #(.W(W), .CW(CW)) bus ();

  strobe_capture_bank #(.W(W), .NCH(NCH), .CW(CW)) dut (
    .clk    (clk),
    .reset  (reset),
    .strb   (strb),
    .mode   (mode),
    .din    (din),
    .out_if (bus.master),
    .pend   (pend)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] ch;
    logic [W-1:0]  data;
    logic          ovr;
  } xfer_t;

  typedef struct {
    logic           vld;
    logic [NCH-1:0] pnd;
    xfer_t          cur;
  } stat_t;

  xfer_t exp_q[$];
  stat_t stat_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  // Reference model: per-channel mailbox (full flag, word, overrun) plus the
  // presented channel and the round-robin start point.
  bit           m_pend [NCH];
  logic [W-1:0] m_hold [NCH];
  bit           m_ovr  [NCH];
  bit           m_prev [NCH];
  bit           m_pres;
  int           m_sel;
  int           m_ptr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_pend[k] = 0; m_hold[k] = '0; m_ovr[k] = 0; m_prev[k] = 0;
    end
    m_pres = 0; m_sel = 0; m_ptr = 0;
  endtask

  // Drive one clock cycle of stimulus and advance the model across the next edge.
  task automatic cycle(input logic [NCH-1:0] s, input logic [2*NCH-1:0] md,
                       input logic [W*NCH-1:0] d, input bit rdy);
    stat_t st;
    bit    fire, pop, hs;
    int    nsel;
    @(posedge clk); #1;
    strb = s; mode = md; din = d; bus.out_ready = rdy;
    st.vld = m_pres;
    for (int k = 0; k < NCH; k++) st.pnd[k] = m_pend[k];
    st.cur.ch   = CW'(m_sel);
    st.cur.data = m_hold[m_sel];
    st.cur.ovr  = m_ovr[m_sel];
    stat_q.push_back(st);
    hs = m_pres && rdy;
    if (hs) exp_q.push_back(st.cur);
    nsel = -1;
    if (!m_pres)
      for (int i = 0; i < NCH; i++)
        if (nsel < 0 && m_pend[(m_ptr + i) % NCH]) nsel = (m_ptr + i) % NCH;
    for (int k = 0; k < NCH; k++) begin
      case (md[2*k +: 2])
        2'b00:   fire = s[k];
        2'b01:   fire = s[k] && !m_prev[k];
        2'b10:   fire = !s[k] && m_prev[k];
        default: fire = s[k] != m_prev[k];
      endcase
      pop = hs && (m_sel == k);
      if (fire) begin
        m_ovr[k]  = m_pend[k] && !pop;
        m_hold[k] = d[W*k +: W];
        m_pend[k] = 1;
      end else if (pop) begin
        m_pend[k] = 0;
        m_ovr[k]  = 0;
      end
      m_prev[k] = s[k];
    end
    if (hs) begin
      m_pres = 0;
      m_ptr  = (m_sel + 1) % NCH;
    end else if (nsel >= 0) begin
      m_pres = 1;
      m_sel  = nsel;
    end
  endtask

  task automatic do_reset(input int ncyc);
    @(posedge clk); #1;
    reset = 1'b1; strb = '0; bus.out_ready = 1'b0;
    model_reset();
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data",  32'(bus.out_data),  0);
    chk("rst_out_ch",    32'(bus.out_ch),    0);
    chk("rst_out_ovr",   32'(bus.out_ovr),   0);
    chk("rst_pend",      32'(pend),          0);
    repeat (ncyc) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Monitor: compares per-cycle status and every handshake against the scoreboard.
  initial begin : monitor
    stat_t st;
    xfer_t ex;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (stat_q.size() > 0) begin
          st = stat_q.pop_front();
          chk("out_valid", 32'(bus.out_valid), 32'(st.vld));
          chk("pend",      32'(pend),          32'(st.pnd));
          if (st.vld) begin
            chk("out_ch",   32'(bus.out_ch),   32'(st.cur.ch));
            chk("out_data", 32'(bus.out_data), 32'(st.cur.data));
            chk("out_ovr",  32'(bus.out_ovr),  32'(st.cur.ovr));
          end
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL handshake: got unexpected ch %0d data %0h, expected none", bus.out_ch, bus.out_data);
          end else begin
            ex = exp_q.pop_front();
            chk("hs_ch",   32'(bus.out_ch),   32'(ex.ch));
            chk("hs_data", 32'(bus.out_data), 32'(ex.data));
            chk("hs_ovr",  32'(bus.out_ovr),  32'(ex.ovr));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  function automatic logic [2*NCH-1:0] all_mode(input logic [1:0] m);
    return {NCH{m}};
  endfunction

  initial begin : stim
    logic [NCH-1:0]     s_cur;
    logic [2*NCH-1:0]   md;
    logic [W*NCH-1:0]   d;
    int                 tog, rdy_pct, rst_at;
    bus.out_ready = 1'b0;
    model_reset();
    do_reset(2);

    // Rising-edge capture on ch0, then a read.
    md = all_mode(2'b01);
    d  = 32'h0000_00A5;
    repeat (2) cycle('0, md, d, 0);
    cycle(4'b0001, md, d, 0);
    cycle(4'b0001, md, d, 0);
    repeat (4) cycle(4'b0001, md, d, 1);
    cycle('0, md, d, 1);

    // Level mode overrun on ch1.
    md = all_mode(2'b00);
    cycle(4'b0010, md, 32'h0000_0100, 0);
    cycle(4'b0010, md, 32'h0000_0200, 0);
    cycle(4'b0010, md, 32'h0000_0300, 0);
    repeat (3) cycle('0, md, '0, 0);
    repeat (3) cycle('0, md, '0, 1);

    // All channels fire on both edges; two bursts.
    md = all_mode(2'b11);
    cycle(4'b1111, md, 32'h4433_2211, 1);
    repeat (10) cycle(4'b1111, md, 32'hDEAD_BEEF, 1);
    cycle(4'b0000, md, 32'h8877_6655, 1);
    repeat (10) cycle(4'b0000, md, 32'h0, 1);

    // Falling-edge mode on ch2.
    md = all_mode(2'b10);
    repeat (4) cycle(4'b0100, md, 32'h0011_0000, 1);
    repeat (4) cycle(4'b0000, md, 32'h0022_0000, 1);
    repeat (3) cycle(4'b0100, md, 32'h0033_0000, 1);

    // Fire on ch1 in its own handshake cycle.
    md = all_mode(2'b01);
    cycle(4'b0010, md, 32'h0000_1100, 0);
    cycle(4'b0000, md, 32'h0, 0);
    cycle(4'b0000, md, 32'h0, 0);
    cycle(4'b0010, md, 32'h0000_2200, 1);
    repeat (5) cycle(4'b0000, md, 32'h0, 1);

    // Reset while presenting with three channels pending.
    md = all_mode(2'b00);
    cycle(4'b0111, md, 32'h0033_2211, 0);
    repeat (3) cycle('0, md, '0, 0);
    do_reset(2);
    repeat (6) cycle('0, md, '0, 1);

    // Randomized phases.
    s_cur = '0;
    for (int ph = 0; ph < 8; ph++) begin
      md      = (2*NCH)'($urandom);
      tog     = $urandom_range(5, 60);
      rdy_pct = $urandom_range(10, 100);
      rst_at  = (ph == 5) ? $urandom_range(50, 250) : -1;
      for (int c = 0; c < 300; c++) begin
        if (c == rst_at) begin
          do_reset(1);
          s_cur = '0;
        end
        for (int k = 0; k < NCH; k++)
          if ($urandom_range(0, 99) < tog) s_cur[k] = ~s_cur[k];
        d = (W*NCH)'($urandom);
        cycle(s_cur, md, d, $urandom_range(0, 99) < rdy_pct);
      end
    end
    repeat (12) cycle('0, '0, '0, 1);

    @(posedge clk); #1;
    chk("exp_q_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
